// File: rtl/mips_mem_ctrl.sv
// Unified instruction/data memory with a wait-state controller for a multicycle MIPS datapath.
// Optional misaligned-access checking (mem_err port) is enabled by defining MEM_ALIGN_CHECK_EN.
module mips_mem_ctrl #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        mem_err,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    misal_q, misal_d;
  logic [31:0]             rdata_q;
  logic                    mem_we, mem_re;

  logic [31:0] mem [2**DEPTH_LOG2];

  // Upper address bits alias onto the array; byte offset only matters with the align check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    misal_d = misal_q;
    ready_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          op_wr_d = mem_write;
          idx_d   = addr[DEPTH_LOG2+1:2];
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
`ifdef MEM_ALIGN_CHECK_EN
          misal_d = (addr[1:0] != 2'b00);
`else
          misal_d = 1'b0;
`endif
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // busy covers the whole access including the completion cycle
    busy_d = (state_d != S_IDLE) || ready_d;
  end

  assign mem_we = (state_q == S_ACCESS) && op_wr_q && !misal_q && !rst;
  assign mem_re = (state_q == S_ACCESS) && !op_wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      misal_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      misal_q <= misal_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Array port and its output register kept together so the RAM maps onto block memory.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
    if (rst) rdata_q <= '0;
    else if (mem_re) rdata_q <= misal_q ? 32'h0 : mem[idx_q];
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign err_d = (state_q == S_ACCESS) && misal_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign mem_err = err_q;
`endif

  assign rdata     = rdata_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Scoreboard testbench for mips_mem_ctrl: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_mips_mem_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] ad    [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        bsy   [2];
`ifdef MEM_ALIGN_CHECK_EN
  logic        err   [2];
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mdl [int];
  logic [31:0] exp_rd [2];
  logic [31:0] sb [$];

  mips_mem_ctrl #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(rdata[0]), .mem_ready(rdy[0]),
`ifdef MEM_ALIGN_CHECK_EN
    .mem_err(err[0]),
`endif
    .busy(bsy[0])
  );

  mips_mem_ctrl #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rdata[1]), .mem_ready(rdy[1]),
`ifdef MEM_ALIGN_CHECK_EN
    .mem_err(err[1]),
`endif
    .busy(bsy[1])
  );

  function automatic int wait_of(input int w);
    return (w == 0) ? 2 : 0;
  endfunction

  // One full transaction on instance w; checks every cycle of the access and the idle cycle after.
  task automatic access(input int w, input bit r, input bit wrt,
                        input logic [31:0] a, input logic [31:0] d);
    int          key;
    int          lat;
    bit          mis;
    logic [31:0] exp;
    logic [31:0] popped;
    logic [33:0] got, want;
    key = w * 256 + int'(a[9:2]);
    lat = wait_of(w) + 1;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`endif
    if (wrt)      exp = exp_rd[w];
    else if (mis) exp = 32'h0;
    else          exp = mdl.exists(key) ? mdl[key] : 32'h0;
    sb.push_back(exp);
    rd[w] = r; wr[w] = wrt; ad[w] = a; wd[w] = d;
    @(posedge clk);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      got = {rdy[w], bsy[w], rdata[w]};
      if (k == lat) begin
        popped = sb.pop_front();
        want = {1'b1, 1'b1, popped};
      end else begin
        want = {1'b0, 1'b1, exp_rd[w]};
      end
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL access_cycle dut%0d addr=%h k=%0d got rdy/busy/rdata=%h want=%h", w, a, k, got, want);
      end
`ifdef MEM_ALIGN_CHECK_EN
      tests_run++;
      if (err[w] !== ((k == lat) && mis)) begin
        tests_failed++;
        $display("FAIL mem_err dut%0d addr=%h k=%0d got=%b want=%b", w, a, k, err[w], (k == lat) && mis);
      end
`endif
      if (k == lat) begin
        rd[w] = 1'b0; wr[w] = 1'b0;
        if (wrt && !mis) mdl[key] = d;
        if (!wrt) exp_rd[w] = popped;
      end
    end
    @(negedge clk);
    tests_run++;
    if ({rdy[w], bsy[w]} !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_after dut%0d addr=%h got rdy/busy=%b%b want=00", w, a, rdy[w], bsy[w]);
    end
    $display("[TB] dut%0d rd=%0b wr=%0b addr=%h wdata=%h rdata=%h", w, r, wrt, a, d, rdata[w]);
  endtask

  task automatic test_reset();
    for (int w = 0; w < 2; w++) begin
      rst[w] = 1'b1; rd[w] = 1'b0; wr[w] = 1'b0; ad[w] = '0; wd[w] = '0; exp_rd[w] = '0;
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) rst[w] = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      tests_run++;
      if ({rdy[w], bsy[w], rdata[w]} !== 34'h0) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d got rdy=%b busy=%b rdata=%h want all zero", w, rdy[w], bsy[w], rdata[w]);
      end
      $display("[TB] dut%0d reset released", w);
    end
  endtask

  task automatic test_read();
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_write_read();
    access(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [33:0] want [4];
    access(1, 1'b0, 1'b1, 32'h0, 32'h0BADF00D);
    access(1, 1'b0, 1'b1, 32'h4, 32'hCAFE0001);
    sb.push_back(32'h0BADF00D);
    sb.push_back(32'hCAFE0001);
    rd[1] = 1'b1; ad[1] = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1 || c == 3) begin
        e = sb.pop_front();
        want[c] = {1'b1, 1'b1, e};
      end else begin
        want[c] = {1'b0, 1'b1, exp_rd[1]};
      end
      tests_run++;
      if ({rdy[1], bsy[1], rdata[1]} !== want[c]) begin
        tests_failed++;
        $display("FAIL back_to_back cycle=%0d got=%h want=%h", c, {rdy[1], bsy[1], rdata[1]}, want[c]);
      end
      if (c == 1) begin exp_rd[1] = e; ad[1] = 32'h4; end
      if (c == 3) begin exp_rd[1] = e; rd[1] = 1'b0; end
      $display("[TB] dut1 held read cycle=%0d rdy=%b rdata=%h", c, rdy[1], rdata[1]);
    end
    @(negedge clk);
    tests_run++;
    if ({rdy[1], bsy[1]} !== 2'b00) begin
      tests_failed++;
      $display("FAIL back_to_back_idle got rdy/busy=%b%b want=00", rdy[1], bsy[1]);
    end
  endtask

  task automatic test_reset_abort();
    access(0, 1'b0, 1'b1, 32'h8, 32'h11112222);
    wr[0] = 1'b1; ad[0] = 32'h8; wd[0] = 32'hAAAA5555;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0; wr[0] = 1'b0;
    exp_rd[0] = 32'h0;
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if ({rdy[0], bsy[0], rdata[0]} !== 34'h0) begin
        tests_failed++;
        $display("FAIL reset_abort cycle=%0d got rdy=%b busy=%b rdata=%h want 0/0/0", c, rdy[0], bsy[0], rdata[0]);
      end
      @(negedge clk);
    end
    $display("[TB] dut0 write 0x8 aborted by reset");
    access(0, 1'b1, 1'b0, 32'h8, 32'h0);
  endtask

  task automatic test_both_high();
    access(0, 1'b1, 1'b1, 32'h30, 32'h77);
    access(0, 1'b1, 1'b0, 32'h30, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = {22'($urandom), 8'($urandom), 2'b00};
      access(0, 1'b0, 1'b1, a, $urandom);
      access(0, 1'b1, 1'b0, a, 32'h0);
    end
    access(0, 1'b1, 1'b0, 32'hFFFF_F410, 32'h0);
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misaligned();
    access(0, 1'b0, 1'b1, 32'h40, 32'h5A5A5A5A);
    access(0, 1'b0, 1'b1, 32'h41, 32'hFFFFFFFF);
    access(0, 1'b1, 1'b0, 32'h40, 32'h0);
    access(0, 1'b1, 1'b0, 32'h41, 32'h0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_back_to_back();
    test_reset_abort();
    test_both_high();
    test_random();
`ifdef MEM_ALIGN_CHECK_EN
    test_misaligned();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
